axis_packet_generator: RTL and testbench
========================================

# axis_packet_generator

Upstream AXI-Stream source for the 256-bit packet counting stage. On a start pulse it emits a programmed number of packets of a programmed byte length on a 32-byte-wide AXI-Stream master port. The payload is a deterministic byte pattern, tkeep is correct on partial last beats, and idle gaps between packets are programmable. It drives the counter's `axisin_*` port directly, and its counters let a bench or LEDs cross-check the downstream packet and byte counts.

## Interface
Parameters:
- LEN_WIDTH, 16, width of `pkt_len` and of the internal bytes-left counter
- CNT_WIDTH, 8, width of `num_packets`, `gap_cycles` and `packets_sent`

Ports:
- clk  in  1  single clock; all logic on the rising edge
- resent  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches configuration and begins a run (ignored unless IDLE)
- stop  in  1  level; requests end of run after the current packet completes
- pkt_len  in  LEN_WIDTH  packet length in bytes; 1..2^LEN_WIDTH-1
- num_packets  in  CNT_WIDTH  packets per run; 0 = continuous until `stop`
- gap_cycles  in  CNT_WIDTH  idle (tvalid low) cycles inserted after each packet
- axisout_tdata  out  256  payload; byte k occupies bits [8k+7:8k]
- axisout_tkeep  out  32  byte enables, contiguous from bit 0
- axisout_tvalid  out  1  beat valid
- axisout_tlast  out  1  final beat of packet
- axisout_tready  in  1  downstream ready
- busy  out  1  high from accepted start until return to IDLE
- done  out  1  one-cycle pulse on return to IDLE
- cfg_err  out  1  one-cycle pulse when start is rejected (`pkt_len` = 0)
- packets_sent  out  CNT_WIDTH  packets fully handshaken since reset; wraps modulo 2^CNT_WIDTH

## Operation
- All outputs are registered. Reset value of every output is 0, including tdata, tkeep, tvalid, tlast, busy, done, cfg_err and packets_sent. The FSM resets to IDLE.
- FSM states are IDLE, SEND and GAP.
- IDLE behaviour:
  - On `start` with `pkt_len` ≠ 0, latch `pkt_len`, `num_packets` and `gap_cycles`. Clear the run packet index p, set busy, and go to SEND.
  - On `start` with `pkt_len` = 0, pulse cfg_err and stay in IDLE.
- SEND behaviour:
  - tvalid is high.
  - Bytes-left counter b starts at the latched length and decrements by 32 per handshake (tvalid & tready).
  - A beat is last when b ≤ 32. It then carries tlast = 1 and tkeep = (b == 32) ? 32'hFFFF_FFFF : (1 << b) - 1. Non-last beats carry tkeep = all ones and tlast = 0.
  - Payload: byte k of beat n of packet p = (p + 32n + k) mod 256.
- End of packet (handshake on the last beat):
  - packets_sent and p increment.
  - If `stop` is sampled high on that cycle, or p+1 == latched num_packets (num_packets ≠ 0), the run ends: go to IDLE, drop busy, pulse done.
  - Otherwise go to GAP, or go straight to SEND of the next packet if gap = 0.
- GAP behaviour: tvalid is low for exactly `gap_cycles` cycles, then SEND.
- `stop` never truncates a packet. If `stop` is asserted during GAP, the run ends at the end of GAP without starting another packet.
- Configuration inputs are ignored while busy. `start` while busy is ignored, with no error pulse.

## Timing
- `start` sampled at edge N gives tvalid = 1 with the first beat after edge N+1.
- AXI-Stream source rules:
  - tvalid never depends combinationally on tready.
  - Once tvalid is high, tdata, tkeep and tlast hold until the handshake.
  - The next beat is presented on the cycle after the handshake, so tready held high gives one beat per cycle.
- With tready held high, a packet occupies ceil(L/32) cycles plus `gap_cycles` idle cycles. With gap = 0, consecutive packets are back-to-back with no tvalid bubble.
- tready low stalls in place with no loss, duplication or change of data.
- done, busy-low and the final packets_sent value appear on the edge after the final last-beat handshake.
- packets_sent wraps from 2^CNT_WIDTH-1 to 0 without affecting the run.
- Reset mid-packet: all outputs are 0 after the next edge, and downstream sees a truncated packet with no tlast. This is acceptable and documented.
- Simultaneous `start` and `resent`: reset wins.

## Test plan
- L=70, num=1, gap=0, tready=1 -> 3 beats; keep FFFFFFFF, FFFFFFFF, 0000003F; tlast on beat 3; beat 3 byte 0 = 0x40; done 1 cycle later; packets_sent=1.
- L=64, num=3, gap=2, tready=1 -> each packet is 2 beats, last keep FFFFFFFF; 2 tvalid-low cycles between packets; byte 0 of packets = 0x00, 0x01, 0x02; packets_sent=3.
- L=1, num=4, gap=0 -> 4 back-to-back single beats, each tlast=1, keep=00000001; tvalid high 4 consecutive cycles.
- L=100, num=2, random tready (50%) -> tdata/tkeep/tlast stable during every stall; byte stream identical to the tready=1 run; a downstream counter sees 2 packets, last-beat keep 0000000F.
- num=0, L=40, `stop` raised mid-second-packet -> second packet completes (keep FFFFFFFF then 000000FF), then IDLE, done pulse, packets_sent=2; `start` while busy ignored.
- `start` with L=0 -> cfg_err pulse, busy stays 0, tvalid stays 0; `resent` mid-packet -> all outputs 0 next cycle, FSM in IDLE.

Source files
------------

// File: rtl/axis_packet_generator.sv
// ============================================================================
// Module      : axis_packet_generator
// Description : 256-bit AXI-Stream packet source with a programmable length,
//               packet count, inter-packet gap and deterministic byte payload.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_packet_generator #(
    parameter int LEN_WIDTH = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 resent,
    input  logic                 start,
    input  logic                 stop,
    input  logic [LEN_WIDTH-1:0] pkt_len,
    input  logic [CNT_WIDTH-1:0] num_packets,
    input  logic [CNT_WIDTH-1:0] gap_cycles,
    output logic [255:0]         axisout_tdata,
    output logic [31:0]          axisout_tkeep,
    output logic                 axisout_tvalid,
    output logic                 axisout_tlast,
    input  logic                 axisout_tready,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err,
    output logic [CNT_WIDTH-1:0] packets_sent
);

    localparam int c_BEAT_BYTES = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [CNT_WIDTH-1:0] num_q, num_d;
    logic [CNT_WIDTH-1:0] gap_q, gap_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] p_q, p_d;
    logic [7:0]           seed_q, seed_d;
    logic [7:0]           base_q, base_d;
    logic [LEN_WIDTH-1:0] b_q, b_d;
    logic                 stop_pend_q, stop_pend_d;
    logic [255:0]         tdata_q, tdata_d;
    logic [31:0]          tkeep_q, tkeep_d;
    logic                 tvalid_q, tvalid_d;
    logic                 tlast_q, tlast_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cfg_err_q, cfg_err_d;
    logic [CNT_WIDTH-1:0] sent_q, sent_d;

    logic                 w_hs;
    logic                 w_end_run;
    logic                 w_load;
    logic [LEN_WIDTH-1:0] w_b_load;
    logic [7:0]           w_base_load;

    function automatic logic [255:0] beat_data(input logic [7:0] base);
        logic [255:0] d;
        d = '0;
        for (int k = 0; k < c_BEAT_BYTES; k++) begin
            d[8*k +: 8] = base + 8'(k);
        end
        return d;
    endfunction

    function automatic logic beat_is_last(input logic [LEN_WIDTH-1:0] b);
        logic [LEN_WIDTH+5:0] bx;
        bx = {6'd0, b};
        return bx <= (LEN_WIDTH+6)'(c_BEAT_BYTES);
    endfunction

    function automatic logic [31:0] beat_keep(input logic [LEN_WIDTH-1:0] b);
        logic [LEN_WIDTH+5:0] bx;
        bx = {6'd0, b};
        if (bx >= (LEN_WIDTH+6)'(c_BEAT_BYTES)) begin
            return '1;
        end
        return (32'd1 << bx[4:0]) - 32'd1;
    endfunction

    assign w_hs      = tvalid_q & axisout_tready;
    assign w_end_run = stop | ((num_q != '0) && ((p_q + CNT_WIDTH'(1)) == num_q));

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        num_d       = num_q;
        gap_d       = gap_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        seed_d      = seed_q;
        base_d      = base_q;
        b_d         = b_q;
        stop_pend_d = stop_pend_q;
        tdata_d     = tdata_q;
        tkeep_d     = tkeep_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;
        sent_d      = sent_q;
        w_load      = 1'b0;
        w_b_load    = b_q;
        w_base_load = base_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (pkt_len != '0) begin
                        len_d   = pkt_len;
                        num_d   = num_packets;
                        gap_d   = gap_cycles;
                        p_d     = '0;
                        seed_d  = '0;
                        base_d  = '0;
                        b_d     = pkt_len;
                        busy_d  = 1'b1;
                        state_d = S_SEND;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end

            S_SEND: begin
                // First SEND cycle of a run only stages the opening beat
                if (!tvalid_q) begin
                    w_load = 1'b1;
                end else if (w_hs) begin
                    if (!tlast_q) begin
                        w_load      = 1'b1;
                        w_b_load    = b_q - LEN_WIDTH'(c_BEAT_BYTES);
                        w_base_load = base_q + 8'(c_BEAT_BYTES);
                    end else begin
                        sent_d   = sent_q + CNT_WIDTH'(1);
                        p_d      = p_q + CNT_WIDTH'(1);
                        seed_d   = seed_q + 8'd1;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tkeep_d  = '0;
                        tdata_d  = '0;
                        if (w_end_run) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else if (gap_q == '0) begin
                            w_load      = 1'b1;
                            w_b_load    = len_q;
                            w_base_load = seed_q + 8'd1;
                        end else begin
                            cnt_d       = gap_q;
                            stop_pend_d = 1'b0;
                            state_d     = S_GAP;
                        end
                    end
                end
            end

            S_GAP: begin
                stop_pend_d = stop_pend_q | stop;
                if (cnt_q <= CNT_WIDTH'(1)) begin
                    stop_pend_d = 1'b0;
                    if (stop_pend_q | stop) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        w_load      = 1'b1;
                        w_b_load    = len_q;
                        w_base_load = seed_q;
                        state_d     = S_SEND;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_load) begin
            b_d      = w_b_load;
            base_d   = w_base_load;
            tvalid_d = 1'b1;
            tdata_d  = beat_data(w_base_load);
            tkeep_d  = beat_keep(w_b_load);
            tlast_d  = beat_is_last(w_b_load);
        end
    end

    always_ff @(posedge clk) begin
        if (resent) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            num_q       <= '0;
            gap_q       <= '0;
            cnt_q       <= '0;
            p_q         <= '0;
            seed_q      <= '0;
            base_q      <= '0;
            b_q         <= '0;
            stop_pend_q <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            sent_q      <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            num_q       <= num_d;
            gap_q       <= gap_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            seed_q      <= seed_d;
            base_q      <= base_d;
            b_q         <= b_d;
            stop_pend_q <= stop_pend_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            sent_q      <= sent_d;
        end
    end

    assign axisout_tdata  = tdata_q;
    assign axisout_tkeep  = tkeep_q;
    assign axisout_tvalid = tvalid_q;
    assign axisout_tlast  = tlast_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign cfg_err        = cfg_err_q;
    assign packets_sent   = sent_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_packet_generator.sv
// ============================================================================
// Module      : tb_axis_packet_generator
// Description : Scoreboard bench for axis_packet_generator using directed runs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_packet_generator;

    logic         clk = 1'b0;
    logic         resent = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [15:0]  pkt_len = '0;
    logic [7:0]   num_packets = '0;
    logic [7:0]   gap_cycles = '0;
    logic [255:0] axisout_tdata;
    logic [31:0]  axisout_tkeep;
    logic         axisout_tvalid;
    logic         axisout_tlast;
    logic         axisout_tready;
    logic         busy;
    logic         done;
    logic         cfg_err;
    logic [7:0]   packets_sent;

    logic rdy_fix = 1'b1;
    logic rand_mode = 1'b0;
    logic rnd_bit = 1'b1;
    assign axisout_tready = rand_mode ? rnd_bit : rdy_fix;

    axis_packet_generator #(.LEN_WIDTH(16), .CNT_WIDTH(8)) dut (
        .clk            (clk),
        .resent         (resent),
        .start          (start),
        .stop           (stop),
        .pkt_len        (pkt_len),
        .num_packets    (num_packets),
        .gap_cycles     (gap_cycles),
        .axisout_tdata  (axisout_tdata),
        .axisout_tkeep  (axisout_tkeep),
        .axisout_tvalid (axisout_tvalid),
        .axisout_tlast  (axisout_tlast),
        .axisout_tready (axisout_tready),
        .busy           (busy),
        .done           (done),
        .cfg_err        (cfg_err),
        .packets_sent   (packets_sent)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [255:0] data;
        logic [31:0]  keep;
        logic         last;
    } beat_t;

    beat_t exp_q[$];
    int    gap_q[$];

    task automatic push_packets(input int len, input int num);
        beat_t e;
        for (int p = 0; p < num; p++) begin
            for (int n = 0; n < (len + 31) / 32; n++) begin
                int b;
                b      = len - 32 * n;
                e.last = (b <= 32);
                e.keep = (b >= 32) ? 32'hFFFF_FFFF : ((32'd1 << b) - 32'd1);
                for (int k = 0; k < 32; k++) begin
                    e.data[8*k +: 8] = 8'((p + 32 * n + k) % 256);
                end
                exp_q.push_back(e);
            end
        end
    endtask

    // Monitor: scoreboard pop on handshake, stall stability, gap measurement
    int           hs_cnt = 0;
    int           last_hs_cyc = 0;
    int           cfg_pulses = 0;
    logic [31:0]  last_keep = '0;
    logic [7:0]   last_b0 = '0;
    logic         held = 1'b0;
    logic [255:0] h_data = '0;
    logic [31:0]  h_keep = '0;
    logic         h_last = 1'b0;
    int           low_run = 0;
    int           pkts_run = 0;
    logic         in_pkt = 1'b0;

    always @(negedge clk) begin
        beat_t e;
        if (axisout_tvalid && held) begin
            check("stall_data", axisout_tdata, h_data);
            check("stall_keep", 256'(axisout_tkeep), 256'(h_keep));
            check("stall_last", 256'(axisout_tlast), 256'(h_last));
        end
        if (cfg_err) cfg_pulses++;
        if (!busy) begin
            in_pkt   = 1'b0;
            pkts_run = 0;
            low_run  = 0;
        end else if (!axisout_tvalid) begin
            low_run++;
        end else if (!in_pkt) begin
            if (pkts_run > 0) gap_q.push_back(low_run);
            in_pkt  = 1'b1;
            low_run = 0;
        end
        if (axisout_tvalid && axisout_tready) begin
            hs_cnt++;
            last_hs_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("sb_underflow", 256'(exp_q.size()), 256'(1));
            end else begin
                e = exp_q.pop_front();
                check("beat_data", axisout_tdata, e.data);
                check("beat_keep", 256'(axisout_tkeep), 256'(e.keep));
                check("beat_last", 256'(axisout_tlast), 256'(e.last));
            end
            if (axisout_tlast) begin
                in_pkt    = 1'b0;
                pkts_run++;
                last_keep = axisout_tkeep;
                last_b0   = axisout_tdata[7:0];
            end
        end
        held   = axisout_tvalid && !axisout_tready;
        h_data = axisout_tdata;
        h_keep = axisout_tkeep;
        h_last = axisout_tlast;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resent = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        tick();
        tick();
        resent = 1'b0;
    endtask

    task automatic pulse_start(input int len, input int num, input int gap);
        pkt_len     = 16'(len);
        num_packets = 8'(num);
        gap_cycles  = 8'(gap);
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int done_cyc;
        int got;
        done_cyc = -1;
        got      = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        if (done_cyc < 0) begin
            check({name, "_done_timeout"}, 256'(got), 256'(1));
        end else begin
            check({name, "_done_latency"}, 256'(done_cyc), 256'(last_hs_cyc + 1));
            check({name, "_busy_low"}, 256'(busy), 256'(0));
        end
    endtask

    task automatic check_gaps(input string name, input int base, input int n, input int g);
        check({name, "_gap_count"}, 256'(gap_q.size() - base), 256'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < gap_q.size()) check({name, "_gap_len"}, 256'(gap_q[base + i]), 256'(g));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gb;
        int hb;
        int cb;
        int i;

        // Reset values
        do_reset();
        check("rst_tvalid", 256'(axisout_tvalid), 256'(0));
        check("rst_tdata", axisout_tdata, 256'(0));
        check("rst_tkeep", 256'(axisout_tkeep), 256'(0));
        check("rst_tlast", 256'(axisout_tlast), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_cfg_err", 256'(cfg_err), 256'(0));
        check("rst_sent", 256'(packets_sent), 256'(0));

        // L=70, one packet
        rdy_fix = 1'b1;
        push_packets(70, 1);
        pulse_start(70, 1, 0);
        check("t1_tvalid_edgeN", 256'(axisout_tvalid), 256'(0));
        check("t1_busy", 256'(busy), 256'(1));
        tick();
        check("t1_tvalid_edgeN1", 256'(axisout_tvalid), 256'(1));
        wait_done(20, "t1");
        check("t1_sent", 256'(packets_sent), 256'(1));
        check("t1_last_keep", 256'(last_keep), 256'(32'h0000_003F));
        check("t1_last_byte0", 256'(last_b0), 256'(8'h40));
        tick();

        // L=64, 3 packets, gap 2
        do_reset();
        gb = gap_q.size();
        push_packets(64, 3);
        pulse_start(64, 3, 2);
        wait_done(60, "t2");
        check("t2_sent", 256'(packets_sent), 256'(3));
        check("t2_last_keep", 256'(last_keep), 256'(32'hFFFF_FFFF));
        check("t2_last_byte0", 256'(last_b0), 256'(8'h22));
        check_gaps("t2", gb, 2, 2);
        tick();

        // L=1, 4 packets back to back
        do_reset();
        gb = gap_q.size();
        push_packets(1, 4);
        pulse_start(1, 4, 0);
        wait_done(30, "t3");
        check("t3_sent", 256'(packets_sent), 256'(4));
        check("t3_last_keep", 256'(last_keep), 256'(32'h0000_0001));
        check("t3_last_byte0", 256'(last_b0), 256'(8'h03));
        check_gaps("t3", gb, 3, 0);
        tick();

        // L=100, 2 packets, random backpressure
        do_reset();
        push_packets(100, 2);
        rand_mode = 1'b1;
        pulse_start(100, 2, 0);
        wait_done(400, "t4");
        rand_mode = 1'b0;
        check("t4_sent", 256'(packets_sent), 256'(2));
        check("t4_last_keep", 256'(last_keep), 256'(32'h0000_000F));
        check("t4_last_byte0", 256'(last_b0), 256'(8'h61));
        tick();

        // Continuous run stopped during the second packet; start while busy ignored
        do_reset();
        rdy_fix = 1'b1;
        gb = gap_q.size();
        hb = hs_cnt;
        cb = cfg_pulses;
        push_packets(40, 2);
        pulse_start(40, 0, 3);
        pkt_len = 16'd0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        i = 0;
        while (hs_cnt < hb + 3 && i < 100) begin
            @(posedge clk);
            i++;
        end
        #1;
        stop = 1'b1;
        wait_done(20, "t5");
        stop = 1'b0;
        check("t5_sent", 256'(packets_sent), 256'(2));
        check("t5_last_keep", 256'(last_keep), 256'(32'h0000_00FF));
        check("t5_no_cfg_err", 256'(cfg_pulses - cb), 256'(0));
        check_gaps("t5", gb, 1, 3);
        tick();
        tick();
        check("t5_idle_tvalid", 256'(axisout_tvalid), 256'(0));

        // Zero length rejected
        do_reset();
        pkt_len     = 16'd0;
        num_packets = 8'd1;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        check("t6_cfg_err", 256'(cfg_err), 256'(1));
        check("t6_busy", 256'(busy), 256'(0));
        check("t6_tvalid", 256'(axisout_tvalid), 256'(0));
        tick();
        check("t6_cfg_err_pulse", 256'(cfg_err), 256'(0));
        check("t6_tvalid_after", 256'(axisout_tvalid), 256'(0));

        // Reset in the middle of a stalled packet
        rdy_fix = 1'b0;
        pulse_start(200, 1, 0);
        tick();
        tick();
        check("t7_stalled_valid", 256'(axisout_tvalid), 256'(1));
        resent = 1'b1;
        tick();
        check("t7_tvalid", 256'(axisout_tvalid), 256'(0));
        check("t7_tdata", axisout_tdata, 256'(0));
        check("t7_tkeep", 256'(axisout_tkeep), 256'(0));
        check("t7_tlast", 256'(axisout_tlast), 256'(0));
        check("t7_busy", 256'(busy), 256'(0));
        check("t7_sent", 256'(packets_sent), 256'(0));
        resent = 1'b0;
        tick();
        tick();
        check("t7_idle_tvalid", 256'(axisout_tvalid), 256'(0));
        check("t7_idle_busy", 256'(busy), 256'(0));
        rdy_fix = 1'b1;

        check("sb_leftover", 256'(exp_q.size()), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
